// File: rtl/cpu_pkg.sv
// Shared CPU definitions: PC-select codes emitted by the branch checker and
// the redirect unit state encodings.
package cpu_pkg;

   localparam logic [1:0] PCSEL_SEQ = 2'b00;
   localparam logic [1:0] PCSEL_BR  = 2'b01;
   localparam logic [1:0] PCSEL_J   = 2'b10;
   localparam logic [1:0] PCSEL_JR  = 2'b11;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_PEND  = 2'd1,
      ST_FLUSH = 2'd2
   } redirect_state_t;

endpackage

// File: rtl/pc_redirect_unit_mux.sv
// Combinational redirect target select with word-alignment check.
import cpu_pkg::*;

module pc_target_mux (
   input  logic [1:0]  pc_sel,
   input  logic [31:0] branch_target,
   input  logic [31:0] jump_target,
   input  logic [31:0] jr_target,
   output logic [31:0] tgt,
   output logic        req,
   output logic        misalign
);

   always_comb begin
      tgt = '0;
      case (pc_sel)
         PCSEL_BR: tgt = branch_target;
         PCSEL_J:  tgt = jump_target;
         PCSEL_JR: tgt = jr_target;
         default:  tgt = '0;
      endcase
   end

   assign req      = (pc_sel != PCSEL_SEQ);
   assign misalign = |tgt[1:0];

endmodule

// File: rtl/pc_redirect_unit.sv
// Fetch PC owner: applies redirects, buffers them behind a fetch stall and
// squashes the IF/ID wrong-path shadow for FLUSH_CYCLES unstalled cycles.
//
// state | meaning
// RUN   | sequential fetch, redirects accepted directly
// PEND  | redirect buffered in pend_tgt until stall drops
// FLUSH | flush_ifid high, pc_sel ignored while the shadow drains
import cpu_pkg::*;

module pc_redirect_unit #(
   parameter logic [31:0] RESET_PC     = 32'h0000_0000,
   parameter int          FLUSH_CYCLES = 1,
   parameter int          CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       pc_sel,
   input  logic [31:0]      branch_target,
   input  logic [31:0]      jump_target,
   input  logic [31:0]      jr_target,
   input  logic             stall,
   output logic [31:0]      pc,
   output logic [31:0]      pc_plus4,
   output logic             flush_ifid,
   output logic             redirect_pending,
   output logic             misalign_err,
   output logic [CNT_W-1:0] taken_count
);

   localparam logic [1:0] CNT_INIT = 2'(FLUSH_CYCLES - 1);

   redirect_state_t state, state_next;

   logic [31:0]      mux_tgt;
   logic             mux_req;
   logic             mux_misalign;
   logic [31:0]      pend_tgt;
   logic [1:0]       flush_cnt;

   logic             accept;
   logic             buffer;
   logic [31:0]      acc_tgt;
   logic             acc_mis;
   logic [31:0]      pc_next;
   logic [1:0]       cnt_next;
   logic             flush_next;
   logic             pend_next;
   logic [CNT_W-1:0] taken_next;

   pc_target_mux u_mux (
      .pc_sel        (pc_sel),
      .branch_target (branch_target),
      .jump_target   (jump_target),
      .jr_target     (jr_target),
      .tgt           (mux_tgt),
      .req           (mux_req),
      .misalign      (mux_misalign)
   );

   assign pc_plus4 = pc + 32'd4;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state            <= ST_RUN;
         pc               <= RESET_PC;
         flush_ifid       <= 1'b0;
         redirect_pending <= 1'b0;
         misalign_err     <= 1'b0;
         taken_count      <= '0;
         pend_tgt         <= '0;
         flush_cnt        <= '0;
      end else begin
         state            <= state_next;
         pc               <= pc_next;
         flush_ifid       <= flush_next;
         redirect_pending <= pend_next;
         misalign_err     <= accept & acc_mis;
         taken_count      <= taken_next;
         flush_cnt        <= cnt_next;
         if (buffer) pend_tgt <= mux_tgt;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_RUN:   if (mux_req) state_next = stall ? ST_PEND : ST_FLUSH;
         ST_PEND:  if (!stall) state_next = ST_FLUSH;
         ST_FLUSH: if (!stall && flush_cnt == 2'd0) state_next = ST_RUN;
         default:  state_next = ST_RUN;
      endcase
   end

   always_comb begin
      accept     = 1'b0;
      buffer     = 1'b0;
      acc_tgt    = mux_tgt;
      acc_mis    = mux_misalign;
      pc_next    = pc;
      cnt_next   = flush_cnt;
      flush_next = flush_ifid;
      pend_next  = redirect_pending;
      case (state)
         ST_RUN: begin
            if (!stall) begin
               if (mux_req) accept  = 1'b1;
               else         pc_next = pc_plus4;
            end else if (mux_req) begin
               buffer = 1'b1;
            end
         end
         ST_PEND: begin
            // The re-presented pc_sel is ignored; the buffered target wins.
            if (!stall) begin
               accept    = 1'b1;
               acc_tgt   = pend_tgt;
               acc_mis   = |pend_tgt[1:0];
               pend_next = 1'b0;
            end
         end
         ST_FLUSH: begin
            if (!stall) begin
               pc_next = pc_plus4;
               if (flush_cnt == 2'd0) flush_next = 1'b0;
               else                   cnt_next   = flush_cnt - 2'd1;
            end
         end
         default: ;
      endcase
      if (accept) begin
         pc_next    = acc_tgt & ~32'h3;
         flush_next = 1'b1;
         cnt_next   = CNT_INIT;
      end
      if (buffer) pend_next = 1'b1;
      taken_next = taken_count;
      if (accept && taken_count != {CNT_W{1'b1}})
         taken_next = taken_count + CNT_W'(1);
   end

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed bench for pc_redirect_unit: default build plus FLUSH_CYCLES=3 and
// CNT_W=2 builds driven from the same inputs.
module tb_pc_redirect_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  pc_sel;
   logic [31:0] branch_target, jump_target, jr_target;
   logic        stall;

   logic [31:0] pc_a, pc4_a;
   logic        fl_a, pend_a, mis_a;
   logic [15:0] cnt_a;

   logic [31:0] pc_b, pc4_b;
   logic        fl_b, pend_b, mis_b;
   logic [15:0] cnt_b;

   logic [31:0] pc_c, pc4_c;
   logic        fl_c, pend_c, mis_c;
   logic [1:0]  cnt_c;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   pc_redirect_unit dut (
      .clk(clk), .rst_n(rst_n), .pc_sel(pc_sel), .branch_target(branch_target),
      .jump_target(jump_target), .jr_target(jr_target), .stall(stall),
      .pc(pc_a), .pc_plus4(pc4_a), .flush_ifid(fl_a), .redirect_pending(pend_a),
      .misalign_err(mis_a), .taken_count(cnt_a)
   );

   pc_redirect_unit #(.FLUSH_CYCLES(3)) dut_fl3 (
      .clk(clk), .rst_n(rst_n), .pc_sel(pc_sel), .branch_target(branch_target),
      .jump_target(jump_target), .jr_target(jr_target), .stall(stall),
      .pc(pc_b), .pc_plus4(pc4_b), .flush_ifid(fl_b), .redirect_pending(pend_b),
      .misalign_err(mis_b), .taken_count(cnt_b)
   );

   pc_redirect_unit #(.CNT_W(2)) dut_sat (
      .clk(clk), .rst_n(rst_n), .pc_sel(pc_sel), .branch_target(branch_target),
      .jump_target(jump_target), .jr_target(jr_target), .stall(stall),
      .pc(pc_c), .pc_plus4(pc4_c), .flush_ifid(fl_c), .redirect_pending(pend_c),
      .misalign_err(mis_c), .taken_count(cnt_c)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Checks the default instance in one call.
   task automatic check_a(input string tag, input logic [31:0] e_pc, input logic e_fl,
                          input logic e_pend, input logic e_mis, input logic [31:0] e_cnt);
      check_val({tag, ".pc"},    pc_a, e_pc);
      check_val({tag, ".flush"}, 32'(fl_a), 32'(e_fl));
      check_val({tag, ".pend"},  32'(pend_a), 32'(e_pend));
      check_val({tag, ".mis"},   32'(mis_a), 32'(e_mis));
      check_val({tag, ".cnt"},   32'(cnt_a), e_cnt);
   endtask

   task automatic do_reset();
      rst_n = 1'b0; pc_sel = 2'b00; stall = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; pc_sel = 2'b00; stall = 1'b0;
      branch_target = '0; jump_target = '0; jr_target = '0;

      // 1: reset and sequential fetch
      do_reset();
      check_a("rst", 32'h0, 0, 0, 0, 0);
      check_val("rst.pc4", pc4_a, 32'h4);
      for (int i = 1; i <= 4; i++) begin
         tick();
         check_a("seq", 32'(4 * i), 0, 0, 0, 0);
      end

      // 2: taken branch at pc=8, jump during flush ignored
      do_reset();
      tick(); tick();
      check_val("br.pre", pc_a, 32'h8);
      pc_sel = 2'b01; branch_target = 32'h40;
      tick();
      check_a("br", 32'h40, 1, 0, 0, 1);
      pc_sel = 2'b10; jump_target = 32'h200;
      tick();
      check_a("br.flush_ign", 32'h44, 0, 0, 0, 1);
      pc_sel = 2'b00;
      tick();
      check_a("br.seq", 32'h48, 0, 0, 0, 1);

      // 3: Jr under stall buffered for 3 cycles
      pc_sel = 2'b11; jr_target = 32'h100; stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_a("pend.hold", 32'h48, 0, 1, 0, 1);
      end
      jr_target = 32'h500;  // PEND ignores the live target
      stall = 1'b0;
      tick();
      check_a("pend.accept", 32'h100, 1, 0, 0, 2);
      pc_sel = 2'b00;
      tick();
      check_a("pend.after", 32'h104, 0, 0, 0, 2);

      // 4: misaligned Jr, then misaligned branch via the pending path
      pc_sel = 2'b11; jr_target = 32'h103;
      tick();
      check_a("mis.jr", 32'h100, 1, 0, 1, 3);
      pc_sel = 2'b00;
      tick();
      check_a("mis.clear", 32'h104, 0, 0, 0, 3);
      pc_sel = 2'b01; branch_target = 32'h22; stall = 1'b1;
      tick();
      check_a("mis.pend", 32'h104, 0, 1, 0, 3);
      stall = 1'b0;
      tick();
      check_a("mis.pend_acc", 32'h20, 1, 0, 1, 4);
      pc_sel = 2'b00;
      tick();
      check_a("mis.pend_clr", 32'h24, 0, 0, 0, 4);

      // pc+4 wraps at the top of the address space
      pc_sel = 2'b10; jump_target = 32'hFFFF_FFFC;
      tick();
      check_val("wrap.pc", pc_a, 32'hFFFF_FFFC);
      check_val("wrap.pc4", pc4_a, 32'h0);
      pc_sel = 2'b00;
      tick();
      check_val("wrap.next", pc_a, 32'h0);

      // 5: FLUSH_CYCLES=3 with a two-cycle stall mid-flush
      do_reset();
      pc_sel = 2'b01; branch_target = 32'h80;
      tick();
      check_val("fl3.pc0", pc_b, 32'h80);  check_val("fl3.f0", 32'(fl_b), 32'd1);
      pc_sel = 2'b00;
      tick();
      check_val("fl3.pc1", pc_b, 32'h84);  check_val("fl3.f1", 32'(fl_b), 32'd1);
      pc_sel = 2'b11; jr_target = 32'h700; stall = 1'b1;
      tick();
      check_val("fl3.pcs1", pc_b, 32'h84); check_val("fl3.fs1", 32'(fl_b), 32'd1);
      tick();
      check_val("fl3.pcs2", pc_b, 32'h84); check_val("fl3.fs2", 32'(fl_b), 32'd1);
      check_val("fl3.nopend", 32'(pend_b), 32'd0);
      pc_sel = 2'b00; stall = 1'b0;
      tick();
      check_val("fl3.pc2", pc_b, 32'h88);  check_val("fl3.f2", 32'(fl_b), 32'd1);
      tick();
      check_val("fl3.pc3", pc_b, 32'h8C);  check_val("fl3.f3", 32'(fl_b), 32'd0);
      check_val("fl3.cnt", 32'(cnt_b), 32'd1);

      // 6: saturation with CNT_W=2, then reset while pending
      do_reset();
      for (int i = 1; i <= 5; i++) begin
         pc_sel = 2'b01; branch_target = 32'h10;
         tick();
         pc_sel = 2'b00;
         tick();
         check_val($sformatf("sat.%0d", i), 32'(cnt_c), (i > 3) ? 32'd3 : 32'(i));
      end
      pc_sel = 2'b11; jr_target = 32'h300; stall = 1'b1;
      tick();
      check_val("rpend.pend", 32'(pend_c), 32'd1);
      rst_n = 1'b0;
      tick();
      check_val("rpend.pc",   pc_c, 32'h0);
      check_val("rpend.pend0", 32'(pend_c), 32'd0);
      check_val("rpend.fl",   32'(fl_c), 32'd0);
      check_val("rpend.mis",  32'(mis_c), 32'd0);
      check_val("rpend.cnt",  32'(cnt_c), 32'd0);
      rst_n = 1'b1; pc_sel = 2'b00; stall = 1'b0;
      tick();
      check_val("rpend.seq", pc_c, 32'h4);
      check_val("rpend.fl2", 32'(fl_c), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pc_redirect_unit.md
Name: pc_redirect_unit

Overview:
- Consumer end of the branch-check select: takes the 2-bit PC-select code and the three candidate targets, and owns the fetch PC register.
- Applies redirects, with a held-redirect buffer when fetch is stalled, and generates IF/ID flush for the wrong-path shadow.
- Flags misaligned targets and counts taken redirects.
- Sits between the branch checker/ID stage and the IF stage of the pipelined core.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- FLUSH_CYCLES, 1, number of cycles flush_ifid stays high after an accepted redirect; legal range 1..3.
- CNT_W, 16, width of taken_count.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- pc_sel  input  2  00 = PC+4, 01 = branch target, 10 = jump target (J/Jal), 11 = register target (Jr).
- branch_target  input  32  PC-relative branch target from ID.
- jump_target  input  32  pseudo-direct jump target from ID.
- jr_target  input  32  register-sourced target.
- stall  input  1  hazard-unit fetch hold; PC must not advance.
- pc  output  32  current fetch PC (registered).
- pc_plus4  output  32  pc + 4, combinational from pc, wraps modulo 2^32.
- flush_ifid  output  1  squash the IF/ID register (registered).
- redirect_pending  output  1  a redirect is buffered behind a stall.
- misalign_err  output  1  one-cycle pulse: accepted target had bits [1:0] != 0.
- taken_count  output  CNT_W  accepted redirects, saturating.

Behaviour:
- Reset (rst_n == 0 at a clock edge):
  - pc = RESET_PC.
  - flush_ifid, redirect_pending, misalign_err = 0; taken_count = 0.
  - state = RUN; pending buffer cleared.
  - Reset mid-flush or mid-pending discards everything.
- Target mux (combinational): tgt = branch_target / jump_target / jr_target for pc_sel 01 / 10 / 11. Redirect request req = (pc_sel != 00).
- States: RUN, PEND, FLUSH. All transitions occur at the clock edge.
- RUN:
  - stall = 0, req = 0: pc <= pc + 4.
  - stall = 1, req = 0: pc holds.
  - stall = 0, req = 1: accept. pc <= {tgt[31:2], 2'b00}; flush_ifid <= 1; go FLUSH with count = FLUSH_CYCLES - 1.
  - stall = 1, req = 1: buffer. pend_tgt <= tgt; redirect_pending <= 1; pc holds; go PEND.
- PEND:
  - pc_sel is ignored; the stalled ID instruction re-presents the same request.
  - stall = 1: hold everything.
  - stall = 0: accept using pend_tgt exactly as in RUN; redirect_pending <= 0; go FLUSH.
- FLUSH:
  - flush_ifid = 1.
  - pc_sel is ignored, because the wrong-path instruction is being squashed.
  - pc advances by 4 when stall = 0 and holds when stall = 1.
  - count decrements only when stall = 0.
  - When count == 0 and stall = 0: flush_ifid <= 0; go RUN.
- Accept side effects, the same for every accept path:
  - taken_count increments and saturates at all-ones.
  - misalign_err <= 1 for exactly one cycle if the accepted target[1:0] != 0; otherwise 0.
- Latency:
  - A redirect presented with stall = 0 appears on pc on the next edge.
  - flush_ifid rises on the same edge.

Decomposition:
- Shared package (cpu_pkg):
  - PC-select codes PCSEL_SEQ = 2'b00, PCSEL_BR = 2'b01, PCSEL_J = 2'b10, PCSEL_JR = 2'b11. These are the same codes the branch checker emits.
  - State encodings RUN / PEND / FLUSH.
- Sub-module: pc_target_mux, a combinational 4:1 target select plus alignment check. Everything else stays in pc_redirect_unit.

Test Plan:
1. Reset and sequential fetch: rst_n = 0 for 2 cycles, then pc_sel = 00 and stall = 0 for 4 cycles -> pc steps 0, 4, 8, 12, 16; flush_ifid stays 0; taken_count = 0.
2. Taken branch: at pc = 8, pc_sel = 01 with branch_target = 0x40 -> next pc = 0x40, flush_ifid high 1 cycle, taken_count = 1; pc_sel = 10 presented during the flush cycle is ignored.
3. Redirect under stall: pc_sel = 11, jr_target = 0x100, stall = 1 for 3 cycles -> pc holds and redirect_pending = 1. Drop stall -> pc = 0x100 and redirect_pending = 0 on that edge; taken_count increments once only.
4. Misaligned Jr: jr_target = 0x103 -> pc = 0x100, misalign_err pulses 1 cycle.
5. FLUSH_CYCLES = 3 with a stall injected mid-flush -> flush_ifid stays high for 3 unstalled cycles plus the stalled ones; pc frozen while stalled.
6. Saturation and reset mid-op: with CNT_W = 2, 5 redirects -> taken_count = 3. Assert rst_n = 0 while in PEND -> pc = RESET_PC and all flags 0 next cycle.
